// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the fetch stage and the control/decode block.
// Holds the canonical NOP, base opcodes, the fetch FSM encoding and small PC helpers.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Sequential fetch address; wraps naturally at 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Word-align a redirect target by clearing the two byte-offset bits.
  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry {instr,pc} holding register that catches a memory response
// while the IF/ID register is occupied and decode is stalled.
module if_skid_buffer
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_unload,
  input  logic         i_clear,
  input  fetch_entry_t i_entry,
  output fetch_entry_t o_entry,
  output logic         o_full
);

  fetch_entry_t r_entry;
  logic         r_full;

  // Clear outranks load so a flush never leaves a stale word behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full        <= 1'b0;
      r_entry.instr <= NOP_INSTR;
      r_entry.pc    <= 32'h0000_0000;
    end else if (i_clear) begin
      r_full        <= 1'b0;
      r_entry.instr <= NOP_INSTR;
    end else if (i_load) begin
      r_full  <= 1'b1;
      r_entry <= i_entry;
    end else if (i_unload) begin
      r_full <= 1'b0;
    end
  end

  assign o_entry = r_entry;
  assign o_full  = r_full;

endmodule

// File: rtl/instr_fetch_stage.sv
// RV32I fetch stage: owns the PC, keeps one instruction-memory request in flight
// and registers the returned word into IF/ID, with stall and redirect handling.
module instr_fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
)(
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_reg_fetch,
  output logic [31:0] pc_fetch,
  output logic        fetch_valid
);

  fetch_state_t r_state;
  logic [31:0]  r_pc_next;
  logic [31:0]  r_req_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_pc_fetch;
  logic         r_valid;

  logic         w_req_fire;
  logic         w_ifid_free;
  logic         w_load_rsp;
  logic         w_load_skid;
  logic         w_skid_load;
  logic         w_skid_unload;
  logic         w_skid_full;
  logic [31:0]  w_redirect_target;
  fetch_entry_t w_skid_in;
  fetch_entry_t w_skid_out;

  assign imem_req_valid    = (r_state == REQ) && !redirect_valid;
  assign imem_req_addr     = r_pc_next;
  assign w_req_fire        = imem_req_valid && imem_req_ready;
  assign w_ifid_free       = !r_valid || !stall;
  assign w_redirect_target = word_align(redirect_pc);
  assign w_skid_in.instr   = imem_rsp_data;
  assign w_skid_in.pc      = r_req_pc;

  // Route a returning word to IF/ID or the skid buffer; redirect suppresses both.
  always_comb begin
    w_load_rsp    = 1'b0;
    w_load_skid   = 1'b0;
    w_skid_load   = 1'b0;
    w_skid_unload = 1'b0;
    if (redirect_valid) begin
      w_load_rsp  = 1'b0;
    end else begin
      case (r_state)
        WAIT: begin
          if (imem_rsp_valid && w_ifid_free) begin
            w_load_rsp = 1'b1;
          end else if (imem_rsp_valid) begin
            w_skid_load = 1'b1;
          end else begin
            w_load_rsp = 1'b0;
          end
        end
        HOLD: begin
          if (!stall && w_skid_full) begin
            w_load_skid   = 1'b1;
            w_skid_unload = 1'b1;
          end else begin
            w_load_skid = 1'b0;
          end
        end
        default: w_load_rsp = 1'b0;
      endcase
    end
  end

  // Fetch sequencing; a redirect that catches an in-flight request must swallow its response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= REQ;
      r_pc_next <= RESET_PC;
      r_req_pc  <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc_next <= w_redirect_target;
      case (r_state)
        WAIT, DROP: r_state <= imem_rsp_valid ? REQ : DROP;
        default:    r_state <= REQ;
      endcase
    end else begin
      case (r_state)
        REQ: begin
          if (w_req_fire) begin
            r_req_pc  <= r_pc_next;
            r_pc_next <= pc_plus4(r_pc_next);
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (w_load_rsp) begin
            r_state <= REQ;
          end else if (w_skid_load) begin
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_load_skid) begin
            r_state <= REQ;
          end
        end
        DROP: begin
          if (imem_rsp_valid) begin
            r_state <= REQ;
          end
        end
        default: r_state <= REQ;
      endcase
    end
  end

  // IF/ID register: falls back to NOP whenever its contents are consumed or flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_pc_fetch <= RESET_PC;
    end else if (redirect_valid) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end else if (w_load_rsp) begin
      r_valid    <= 1'b1;
      r_instr    <= imem_rsp_data;
      r_pc_fetch <= r_req_pc;
    end else if (w_load_skid) begin
      r_valid    <= 1'b1;
      r_instr    <= w_skid_out.instr;
      r_pc_fetch <= w_skid_out.pc;
    end else if (r_valid && !stall) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end
  end

  if_skid_buffer u_skid (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_clear  (redirect_valid),
    .i_entry  (w_skid_in),
    .o_entry  (w_skid_out),
    .o_full   (w_skid_full)
  );

  assign instr_reg_fetch = r_instr;
  assign pc_fetch        = r_pc_fetch;
  assign fetch_valid     = r_valid;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed timeline plus random traffic, with the
// expected IF/ID stream kept in a queue and checked whenever decode consumes it.
module tb_instr_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr_reg_fetch;
  logic [31:0] pc_fetch;
  logic        fetch_valid;

  // second instance only exercises the PC wrap from the top of memory
  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic        w_hs;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic        w_fv;
  logic [31:0] wrap_addr [2];
  int          wrap_n;

  int   total;
  int   bad;
  int   pops;
  exp_t exp_q[$];
  logic [31:0] gen_pc;
  int   mem_mode;
  int   k_min;
  int   k_max;
  bit   ready_rand;

  bit          pend;
  logic [31:0] pend_addr;
  int          pend_cnt;

  instr_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_reg_fetch(instr_reg_fetch), .pc_fetch(pc_fetch), .fetch_valid(fetch_valid)
  );

  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
    .imem_req_ready(1'b1), .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(32'h0000_0013), .stall(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
    .instr_reg_fetch(w_instr), .pc_fetch(w_pc), .fetch_valid(w_fv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_mode == 0) return 32'h0000_0033;
    return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic top_up();
    while (exp_q.size() < 16) begin
      exp_q.push_back('{pc: gen_pc, instr: mem_word(gen_pc)});
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic refill(input logic [31:0] start);
    exp_q.delete();
    gen_pc = start;
    top_up();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    top_up();
  endtask

  // Instruction memory: one response per accepted request, k cycles later.
  initial begin
    pend = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      imem_req_ready = ready_rand ? (($urandom % 4) != 0) : 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_addr);
          pend = 1'b0;
        end
      end
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
      end else if (imem_req_valid && imem_req_ready) begin
        chk("req_align", {30'd0, imem_req_addr[1:0]}, 32'd0);
        chk("single_outstanding", {31'd0, pend}, 32'd0);
        pend = 1'b1;
        pend_addr = imem_req_addr;
        pend_cnt = $urandom_range(k_max, k_min);
      end
    end
  end

  // Memory for the wrap instance: always ready, k=1.
  initial begin
    w_hs = 1'b0;
    w_rsp_valid = 1'b0;
    wrap_n = 0;
    forever begin
      @(posedge clk);
      #1;
      w_rsp_valid = w_hs;
      @(negedge clk);
      w_hs = !rst && (w_req_valid === 1'b1);
      if (w_hs && wrap_n < 2) begin
        wrap_addr[wrap_n] = w_req_addr;
        wrap_n++;
      end
    end
  end

  // Monitor: each consumed IF/ID entry must be the next expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (fetch_valid && !stall) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got pc %h expected none", pc_fetch);
          end else begin
            e = exp_q.pop_front();
            chk("sb_pc", pc_fetch, e.pc);
            chk("sb_instr", instr_reg_fetch, e.instr);
            pops++;
          end
        end
        if (!fetch_valid) chk("nop_when_invalid", instr_reg_fetch, NOP);
        if (redirect_valid) chk("no_req_on_redirect", {31'd0, imem_req_valid}, 32'd0);
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    logic [31:0] pend_tgt;
    bit redir_p;
    bit rst_p;
    int pops0;
    total = 0; bad = 0; pops = 0;
    mem_mode = 0; k_min = 1; k_max = 1; ready_rand = 1'b0;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    gen_pc = 32'h0;
    tick(); tick();
    chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_instr", instr_reg_fetch, NOP);
    chk("rst_pc", pc_fetch, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);

    // C0: first request, free-run with k=1
    rst = 1'b0;
    refill(32'h0);
    @(negedge clk);
    chk("c0_req_valid", {31'd0, imem_req_valid}, 32'd1);
    @(negedge clk);
    chk("c1_valid", {31'd0, fetch_valid}, 32'd0);
    @(negedge clk);
    chk("c2_valid", {31'd0, fetch_valid}, 32'd1);
    chk("c2_pc", pc_fetch, 32'h0);
    chk("c2_instr", instr_reg_fetch, 32'h0000_0033);
    tick(); @(negedge clk);
    chk("c3_valid", {31'd0, fetch_valid}, 32'd0);
    tick(); stall = 1'b1; @(negedge clk);
    chk("c4_pc", pc_fetch, 32'h4);
    chk("wrap_first", wrap_addr[0], 32'hFFFF_FFFC);
    chk("wrap_second", wrap_addr[1], 32'h0000_0000);

    // stall for five cycles while the response for PC 8 lands in the skid buffer
    tick();
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clk);
      chk("stall_valid", {31'd0, fetch_valid}, 32'd1);
      chk("stall_pc", pc_fetch, 32'h4);
      chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    tick(); stall = 1'b0;
    tick(); @(negedge clk);
    chk("unstall_pc", pc_fetch, 32'h8);
    chk("unstall_valid", {31'd0, fetch_valid}, 32'd1);
    chk("unstall_req_addr", imem_req_addr, 32'hC);
    chk("unstall_req_valid", {31'd0, imem_req_valid}, 32'd1);

    // redirect while the request for 0x10 is outstanding
    tick(); k_min = 3; k_max = 3;
    tick(); @(negedge clk);
    chk("req10_addr", imem_req_addr, 32'h10);
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick(); redirect_valid = 1'b0; refill(32'h100); k_min = 1; k_max = 1;
    @(negedge clk);
    chk("drop_valid", {31'd0, fetch_valid}, 32'd0);
    chk("drop_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick(); @(negedge clk);
    chk("drop2_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick(); stall = 1'b1; @(negedge clk);
    chk("redir_req_addr", imem_req_addr, 32'h100);
    chk("redir_req_valid", {31'd0, imem_req_valid}, 32'd1);
    tick(); @(negedge clk);
    chk("redir_wait_valid", {31'd0, fetch_valid}, 32'd0);
    tick(); @(negedge clk);
    chk("redir_pc", pc_fetch, 32'h100);
    chk("redir_fv", {31'd0, fetch_valid}, 32'd1);

    // redirect with stall held and the skid buffer full
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clk);
    chk("hold_pc", pc_fetch, 32'h100);
    tick(); redirect_valid = 1'b0; stall = 1'b0; refill(32'h200);
    @(negedge clk);
    chk("flush_valid", {31'd0, fetch_valid}, 32'd0);
    chk("flush_req_addr", imem_req_addr, 32'h200);
    tick(); k_min = 3; k_max = 3;
    tick(); @(negedge clk);
    chk("tgt_pc", pc_fetch, 32'h200);

    // reset while waiting on the response for 0x204
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; refill(32'h0); k_min = 1; k_max = 1;
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("mid_rst_pc", pc_fetch, 32'h0);
    chk("mid_rst_req_addr", imem_req_addr, 32'h0);
    tick(); tick(); @(negedge clk);
    chk("post_rst_pc", pc_fetch, 32'h0);
    chk("post_rst_fv", {31'd0, fetch_valid}, 32'd1);

    // random traffic against the scoreboard
    tick(); rst = 1'b1; mem_mode = 1;
    tick(); rst = 1'b0; refill(32'h0);
    ready_rand = 1'b1; k_min = 1; k_max = 3;
    redir_p = 1'b0; rst_p = 1'b0; pend_tgt = 32'h0;
    pops0 = pops;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (rst_p) begin
        rst = 1'b0;
        refill(32'h0);
      end else if (redir_p) begin
        refill(pend_tgt & 32'hFFFF_FFFC);
      end
      rst_p = 1'b0;
      redir_p = 1'b0;
      stall = (($urandom % 10) < 3);
      redirect_valid = (($urandom % 25) == 0);
      if (redirect_valid) begin
        tgt = $urandom;
        if (($urandom % 4) == 0) tgt = 32'hFFFF_FFF0 | ($urandom % 16);
        redirect_pc = tgt;
        pend_tgt = tgt;
        redir_p = 1'b1;
      end
      if (($urandom % 400) == 0) begin
        rst = 1'b1;
        rst_p = 1'b1;
      end
      top_up();
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    redirect_valid = 1'b0;
    stall = 1'b0;
    total++;
    if (pops - pops0 < 150) begin
      bad++;
      $display("FAIL random_progress: got %0d consumed expected at least 150", pops - pops0);
    end
    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- RV32I instruction fetch stage: holds the PC, issues single-outstanding requests to instruction memory, and registers the returned word into the IF/ID register.
- Output `instr_reg_fetch` feeds the control/decode block directly.
- Supports decode back-pressure (stall) and branch/jump redirect (flush), with a one-entry skid buffer so a response is never lost while decode is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, word driven on instr_reg_fetch when invalid or flushed (addi x0,x0,0).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch byte address, bits [1:0] always 0.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_rsp_valid  in  1  response word valid (one per accepted request, in order).
- imem_rsp_data  in  32  instruction word.
- stall  in  1  decode cannot consume IF/ID this cycle.
- redirect_valid  in  1  branch/jump taken, flush and refetch.
- redirect_pc  in  32  redirect target.
- instr_reg_fetch  out  32  IF/ID instruction to control block.
- pc_fetch  out  32  PC of instr_reg_fetch.
- fetch_valid  out  1  IF/ID contents valid.

Behaviour:
Reset (rst=1 at rising edge):
- state=REQ, pc_next=RESET_PC.
- fetch_valid=0, instr_reg_fetch=NOP_INSTR, pc_fetch=RESET_PC.
- Skid buffer empty.

States:
- REQ: drive imem_req_valid = !redirect_valid, imem_req_addr=pc_next. On handshake (valid&&ready), record req_pc=pc_next, pc_next+=4 (mod 2^32; 0xFFFF_FFFC wraps to 0), go WAIT.
- WAIT: on imem_rsp_valid:
  - If IF/ID is free (!fetch_valid || !stall), load instr/pc/valid=1 and go REQ.
  - Otherwise write the skid buffer and go HOLD.
- HOLD: no requests. When stall=0, move skid to IF/ID (valid=1), empty skid, go REQ.
- DROP: wait for imem_rsp_valid, discard the data, go REQ.

IF/ID consumption:
- If the entry is consumed (fetch_valid && !stall) with no new word arriving that cycle, fetch_valid falls to 0 and instr_reg_fetch returns to NOP_INSTR.

Redirect (highest priority, any state):
- Next cycle: fetch_valid=0, instr_reg_fetch=NOP_INSTR, skid emptied.
- pc_next = {redirect_pc[31:2],2'b00}.
- From WAIT, go DROP. If imem_rsp_valid arrives in the redirect cycle itself, discard it and go REQ.
- From REQ/HOLD/DROP, go REQ; DROP is kept if its response is still pending.
- No request is issued in the redirect cycle.
- Redirect overrides stall.

Latency:
- Request accepted in cycle N, response at N+k (k≥1), fetch_valid=1 at the edge ending cycle N+k.
- Best-case throughput: one instruction per 2 cycles (single outstanding request).

Simultaneous events:
- stall=1 with fetch_valid=0: a response still loads IF/ID, because the register is empty.
- rst has priority over redirect.
- Mid-operation rst discards any outstanding response. The memory side must also be reset together with this block.

Decomposition:
- Shared package `riscv_pkg`:
  - NOP_INSTR constant.
  - Opcode constants (shared with the control block).
  - fetch state enum {REQ, WAIT, HOLD, DROP}.
- Sub-module `if_skid_buffer`: one-entry {instr,pc} register with load/unload/clear and a full flag. Instantiated once.

Test Plan:
- Reset then free-run: imem returns 32'h0000_0033 with k=1 -> first fetch_valid 2 cycles after the first handshake; pc_fetch sequence 0,4,8; instr_reg_fetch = 0x33.
- Stall: hold stall=1 for 5 cycles while the response for PC 8 arrives -> IF/ID keeps PC 4, skid holds PC 8, no imem_req_valid. Release -> PC 8 presented next cycle, then a request for 0xC.
- Redirect in WAIT: redirect_pc=32'h0000_0103 while a request for 0x10 is outstanding -> response discarded, next request addr 0x100, fetch_valid low until the 0x100 word arrives.
- Redirect combined with stall, skid full -> skid and IF/ID flushed (NOP, valid=0), next request at the target.
- Wrap: RESET_PC=32'hFFFF_FFFC -> second request addr 32'h0000_0000.
- Reset mid-WAIT: rst asserted one cycle -> outputs return to reset values, next request at RESET_PC.
